// File: rtl/up_regmap_mux.sv
// Up-bus fan-out/fan-in between up_axi and NUM_SLAVES register slaves, with
// independent read/write FSMs and a per-transaction ack watchdog.
// Optional: define UP_REGMAP_MUX_TIMEOUT_CNT_EN to add a timeout counter and last-timeout address.
module up_regmap_mux #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADDEAD
) (
  input  logic                     up_clk,
  input  logic                     up_rst,
  input  logic                     up_wreq,
  input  logic [ADDR_WIDTH-1:0]    up_waddr,
  input  logic [31:0]              up_wdata,
  output logic                     up_wack,
  output logic                     up_werr,
  input  logic                     up_rreq,
  input  logic [ADDR_WIDTH-1:0]    up_raddr,
  output logic [31:0]              up_rdata,
  output logic                     up_rack,
  output logic                     up_rerr,
  output logic                     s_wreq,
  output logic [ADDR_WIDTH-1:0]    s_waddr,
  output logic [31:0]              s_wdata,
  input  logic [NUM_SLAVES-1:0]    s_wack,
  output logic                     s_rreq,
  output logic [ADDR_WIDTH-1:0]    s_raddr,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_rack,
  output logic [1:0]               dbg_state_o
`ifdef UP_REGMAP_MUX_TIMEOUT_CNT_EN
  ,
  output logic [15:0]              up_timeout_count,
  output logic [ADDR_WIDTH-1:0]    up_timeout_addr
`endif
);

  // Handshake: every *req is a one-cycle pulse; each accepted request gets
  // exactly one *ack pulse (with *err on timeout) unless reset intervenes.
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {W_IDLE = 1'b0, W_WAIT = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_WAIT = 1'b1} r_state_e;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic [TW-1:0]           wtimer_q, wtimer_d, rtimer_q, rtimer_d;
  logic                    s_wreq_q, s_wreq_d, s_rreq_q, s_rreq_d;
  logic [ADDR_WIDTH-1:0]   s_waddr_q, s_waddr_d, s_raddr_q, s_raddr_d;
  logic [31:0]             s_wdata_q, s_wdata_d;
  logic                    up_wack_q, up_wack_d, up_werr_q, up_werr_d;
  logic                    up_rack_q, up_rack_d, up_rerr_q, up_rerr_d;
  logic [31:0]             up_rdata_q, up_rdata_d;
  logic [31:0]             rdata_or;

  // Each slave's data only contributes while that slave acks.
  always_comb begin
    rdata_or = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      rdata_or = rdata_or | (s_rdata[32*k +: 32] & {32{s_rack[k]}});
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    wtimer_d  = wtimer_q;
    s_wreq_d  = 1'b0;
    s_waddr_d = s_waddr_q;
    s_wdata_d = s_wdata_q;
    up_wack_d = 1'b0;
    up_werr_d = 1'b0;
    case (w_state_q)
      W_IDLE: if (up_wreq) begin
        s_wreq_d  = 1'b1;
        s_waddr_d = up_waddr;
        s_wdata_d = up_wdata;
        wtimer_d  = '0;
        w_state_d = W_WAIT;
      end
      W_WAIT: if (|s_wack) begin
        up_wack_d = 1'b1;
        w_state_d = W_IDLE;
      end else if (wtimer_q == T_LAST) begin
        up_wack_d = 1'b1;
        up_werr_d = 1'b1;
        w_state_d = W_IDLE;
      end else begin
        wtimer_d = wtimer_q + TW'(1);
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    rtimer_d   = rtimer_q;
    s_rreq_d   = 1'b0;
    s_raddr_d  = s_raddr_q;
    up_rack_d  = 1'b0;
    up_rerr_d  = 1'b0;
    up_rdata_d = '0;
    case (r_state_q)
      R_IDLE: if (up_rreq) begin
        s_rreq_d  = 1'b1;
        s_raddr_d = up_raddr;
        rtimer_d  = '0;
        r_state_d = R_WAIT;
      end
      R_WAIT: if (|s_rack) begin
        up_rack_d  = 1'b1;
        up_rdata_d = rdata_or;
        r_state_d  = R_IDLE;
      end else if (rtimer_q == T_LAST) begin
        up_rack_d  = 1'b1;
        up_rerr_d  = 1'b1;
        up_rdata_d = TIMEOUT_RDATA;
        r_state_d  = R_IDLE;
      end else begin
        rtimer_d = rtimer_q + TW'(1);
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      wtimer_q   <= '0;
      rtimer_q   <= '0;
      s_wreq_q   <= 1'b0;
      s_rreq_q   <= 1'b0;
      s_waddr_q  <= '0;
      s_raddr_q  <= '0;
      s_wdata_q  <= '0;
      up_wack_q  <= 1'b0;
      up_werr_q  <= 1'b0;
      up_rack_q  <= 1'b0;
      up_rerr_q  <= 1'b0;
      up_rdata_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      wtimer_q   <= wtimer_d;
      rtimer_q   <= rtimer_d;
      s_wreq_q   <= s_wreq_d;
      s_rreq_q   <= s_rreq_d;
      s_waddr_q  <= s_waddr_d;
      s_raddr_q  <= s_raddr_d;
      s_wdata_q  <= s_wdata_d;
      up_wack_q  <= up_wack_d;
      up_werr_q  <= up_werr_d;
      up_rack_q  <= up_rack_d;
      up_rerr_q  <= up_rerr_d;
      up_rdata_q <= up_rdata_d;
    end
  end

  assign s_wreq      = s_wreq_q;
  assign s_waddr     = s_waddr_q;
  assign s_wdata     = s_wdata_q;
  assign s_rreq      = s_rreq_q;
  assign s_raddr     = s_raddr_q;
  assign up_wack     = up_wack_q;
  assign up_werr     = up_werr_q;
  assign up_rack     = up_rack_q;
  assign up_rerr     = up_rerr_q;
  assign up_rdata    = up_rdata_q;
  assign dbg_state_o = {r_state_q, w_state_q};

`ifdef UP_REGMAP_MUX_TIMEOUT_CNT_EN
  logic                  w_timeout, r_timeout;
  logic [15:0]           timeout_cnt_q, timeout_cnt_d;
  logic [ADDR_WIDTH-1:0] timeout_addr_q, timeout_addr_d;
  logic [16:0]           cnt_sum;

  assign w_timeout = (w_state_q == W_WAIT) && !(|s_wack) && (wtimer_q == T_LAST);
  assign r_timeout = (r_state_q == R_WAIT) && !(|s_rack) && (rtimer_q == T_LAST);

  // Write address wins when both directions time out together.
  always_comb begin
    cnt_sum        = {1'b0, timeout_cnt_q} + 17'(w_timeout) + 17'(r_timeout);
    timeout_cnt_d  = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    timeout_addr_d = timeout_addr_q;
    if (w_timeout) begin
      timeout_addr_d = s_waddr_q;
    end else if (r_timeout) begin
      timeout_addr_d = s_raddr_q;
    end
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      timeout_cnt_q  <= '0;
      timeout_addr_q <= '0;
    end else begin
      timeout_cnt_q  <= timeout_cnt_d;
      timeout_addr_q <= timeout_addr_d;
    end
  end

  assign up_timeout_count = timeout_cnt_q;
  assign up_timeout_addr  = timeout_addr_q;
`endif

endmodule

// File: tb/tb_up_regmap_mux.sv
// Self-checking bench for up_regmap_mux: scripted slave responses, expected
// acks queued at request time and matched by a negedge monitor.
module tb_up_regmap_mux;
  localparam int NS = 4;
  localparam int AW = 14;
  localparam int TC = 16;
  localparam logic [31:0] TO_DATA = 32'hDEADDEAD;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            up_wreq = 1'b0, up_rreq = 1'b0;
  logic [AW-1:0]   up_waddr = '0, up_raddr = '0;
  logic [31:0]     up_wdata = '0;
  logic            up_wack, up_werr, up_rack, up_rerr;
  logic [31:0]     up_rdata;
  logic            s_wreq, s_rreq;
  logic [AW-1:0]   s_waddr, s_raddr;
  logic [31:0]     s_wdata;
  logic [NS-1:0]   s_wack = '0, s_rack = '0;
  logic [NS*32-1:0] s_rdata = '0;
  logic [1:0]      dbg_state;
`ifdef UP_REGMAP_MUX_TIMEOUT_CNT_EN
  logic [15:0]     up_timeout_count;
  logic [AW-1:0]   up_timeout_addr;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [16:0] exp_w_q[$];  // {cycle, err}
  logic [48:0] exp_r_q[$];  // {cycle, err, rdata}

  up_regmap_mux #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TC)) dut (
    .up_clk(clk), .up_rst(rst),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
    .up_wack(up_wack), .up_werr(up_werr),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata),
    .up_rack(up_rack), .up_rerr(up_rerr),
    .s_wreq(s_wreq), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wack(s_wack),
    .s_rreq(s_rreq), .s_raddr(s_raddr), .s_rdata(s_rdata), .s_rack(s_rack),
    .dbg_state_o(dbg_state)
`ifdef UP_REGMAP_MUX_TIMEOUT_CNT_EN
    , .up_timeout_count(up_timeout_count), .up_timeout_addr(up_timeout_addr)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [16:0] ew;
    logic [48:0] er;
    if (up_wack) begin
      n_cmp++;
      if (exp_w_q.size() == 0) begin
        n_err++;
        $display("FAIL wack_unexpected: wack at cycle %0d, required none", cyc);
      end else begin
        ew = exp_w_q.pop_front();
        if ({cyc[15:0], up_werr} !== ew) begin
          n_err++;
          $display("FAIL wack: got cycle %0d err %0b, required cycle %0d err %0b",
                   cyc, up_werr, ew[16:1], ew[0]);
        end
      end
    end
    if (up_rack) begin
      n_cmp++;
      if (exp_r_q.size() == 0) begin
        n_err++;
        $display("FAIL rack_unexpected: rack at cycle %0d, required none", cyc);
      end else begin
        er = exp_r_q.pop_front();
        if ({cyc[15:0], up_rerr, up_rdata} !== er) begin
          n_err++;
          $display("FAIL rack: got cycle %0d err %0b data %h, required cycle %0d err %0b data %h",
                   cyc, up_rerr, up_rdata, er[48:33], er[32], er[31:0]);
        end
      end
    end else begin
      n_cmp++;
      if ({up_rerr, up_rdata} !== 33'd0) begin
        n_err++;
        $display("FAIL rdata_idle: got err %0b data %h at cycle %0d, required 0", up_rerr, up_rdata, cyc);
      end
    end
    if (up_werr && !up_wack) begin
      n_cmp++;
      n_err++;
      $display("FAIL werr_alone: werr=1 wack=0 at cycle %0d, required werr only with wack", cyc);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Request at relative cycle 0; slave acks at cycle tw/tr with mask wsel/rsel.
  task automatic run_txn(input bit do_w, input int tw, input logic [3:0] wsel,
                         input logic [AW-1:0] wa, input logic [31:0] wd,
                         input bit do_r, input int tr, input logic [3:0] rsel,
                         input logic [AW-1:0] ra, input logic [127:0] rd);
    int c0, wexp, rexp, last;
    bit wok, rok;
    logic [31:0] rexp_d;
    c0   = cyc;
    wok  = do_w && (wsel != 4'd0) && tw >= 1 && tw <= TC;
    rok  = do_r && (rsel != 4'd0) && tr >= 1 && tr <= TC;
    wexp = wok ? tw + 1 : TC + 1;
    rexp = rok ? tr + 1 : TC + 1;
    rexp_d = TO_DATA;
    if (rok) begin
      rexp_d = '0;
      for (int k = 0; k < NS; k++) if (rsel[k]) rexp_d = rexp_d | rd[32*k +: 32];
    end
    if (do_w) exp_w_q.push_back({16'(c0 + wexp), ~wok});
    if (do_r) exp_r_q.push_back({16'(c0 + rexp), ~rok, rexp_d});
    last = 0;
    if (do_w) last = (wexp - 1 > tw) ? wexp - 1 : tw;
    if (do_r) begin
      if (rexp - 1 > last) last = rexp - 1;
      if (tr > last) last = tr;
    end
    for (int n = 0; n <= last; n++) begin
      if (n == 1) begin
        n_cmp++;
        if ({s_wreq, s_rreq, dbg_state} !== {do_w, do_r, do_r, do_w}) begin
          n_err++;
          $display("FAIL fwd_req: got wreq %0b rreq %0b state %b, required %0b %0b %b",
                   s_wreq, s_rreq, dbg_state, do_w, do_r, {do_r, do_w});
        end
      end
      if (n == 2) begin
        n_cmp++;
        if ({s_wreq, s_rreq} !== 2'b00 || (do_w && {s_waddr, s_wdata} !== {wa, wd}) ||
            (do_r && s_raddr !== ra)) begin
          n_err++;
          $display("FAIL fwd_hold: got wreq %0b rreq %0b waddr %h wdata %h raddr %h, required 0 0 %h %h %h",
                   s_wreq, s_rreq, s_waddr, s_wdata, s_raddr, wa, wd, ra);
        end
      end
      up_wreq  = do_w && (n == 0);
      up_rreq  = do_r && (n == 0);
      up_waddr = up_wreq ? wa : AW'($urandom);
      up_wdata = up_wreq ? wd : $urandom;
      up_raddr = up_rreq ? ra : AW'($urandom);
      s_wack   = (do_w && n == tw) ? wsel : 4'd0;
      s_rack   = (do_r && n == tr) ? rsel : 4'd0;
      s_rdata  = rd;
      tick();
    end
    up_wreq = 1'b0;
    up_rreq = 1'b0;
    s_wack  = '0;
    s_rack  = '0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    up_wreq = 1'b1; up_rreq = 1'b1; up_waddr = 14'h1ABC; up_raddr = 14'h0ABC;
    s_wack = 4'hF; s_rack = 4'hF; s_rdata = {4{32'hFFFFFFFF}};
    do_reset();
    up_wreq = 1'b0; up_rreq = 1'b0; s_wack = '0; s_rack = '0; s_rdata = '0;
    n_cmp++;
    if ({up_wack, up_werr, up_rack, up_rerr, up_rdata, s_wreq, s_waddr, s_wdata,
         s_rreq, s_raddr, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got wack %0b rack %0b rdata %h wreq %0b waddr %h rreq %0b raddr %h state %b, required all 0",
               up_wack, up_rack, up_rdata, s_wreq, s_waddr, s_rreq, s_raddr, dbg_state);
    end
  endtask

  task automatic test_read_mux();
    run_txn(0, 0, 4'd0, '0, '0, 1, 2, 4'b0100, 14'h0010,
            {32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF});
    run_txn(0, 0, 4'd0, '0, '0, 1, 1, 4'b0001, 14'h0011,
            {32'h0, 32'h0, 32'hFFFFFFFF, 32'hCAFEF00D});
    repeat (3) tick();
    n_cmp++;
    if (exp_r_q.size() != 0) begin
      n_err++;
      $display("FAIL read_mux_drain: %0d reads left unanswered, required 0", exp_r_q.size());
      exp_r_q.delete();
    end
  endtask

  task automatic test_timeouts();
    run_txn(1, 0, 4'd0, 14'h0123, 32'h0BADF00D, 0, 0, 4'd0, '0, '0);
    run_txn(0, 0, 4'd0, '0, '0, 1, 0, 4'd0, 14'h0200, {4{32'h55AA55AA}});
    run_txn(0, 0, 4'd0, '0, '0, 1, TC, 4'b0001, 14'h0201, {96'h0, 32'h600DCAFE});
    run_txn(0, 0, 4'd0, '0, '0, 1, TC + 1, 4'b0001, 14'h0202, {96'h0, 32'h11111111});
    run_txn(1, TC, 4'b1000, 14'h0124, 32'h1, 0, 0, 4'd0, '0, '0);
    run_txn(1, TC + 1, 4'b1000, 14'h0125, 32'h2, 0, 0, 4'd0, '0, '0);
    repeat (3) tick();
    n_cmp++;
    if (exp_w_q.size() != 0 || exp_r_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout_drain: %0d writes %0d reads unanswered, required 0", exp_w_q.size(), exp_r_q.size());
      exp_w_q.delete();
      exp_r_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    run_txn(1, 2, 4'b0001, 14'h0300, 32'h01020304, 1, 4, 4'b1000, 14'h0301,
            {32'hA5A5A5A5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
    run_txn(1, 3, 4'b0110, 14'h0302, 32'h0, 1, 3, 4'b1111, 14'h0303,
            {32'h000000F0, 32'h00000F00, 32'h0000F000, 32'hF0000000});
    run_txn(1, 0, 4'd0, 14'h0304, 32'h9, 1, 0, 4'd0, 14'h0305, '0);
    repeat (3) tick();
    n_cmp++;
    if (exp_w_q.size() != 0 || exp_r_q.size() != 0) begin
      n_err++;
      $display("FAIL simul_drain: %0d writes %0d reads unanswered, required 0", exp_w_q.size(), exp_r_q.size());
      exp_w_q.delete();
      exp_r_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_txn(1, 1, 4'(1 << (i % 4)), AW'(14'h0400 + i), $urandom,
              1, 1, 4'(1 << ((i + 1) % 4)), AW'(14'h0500 + i),
              {$urandom, $urandom, $urandom, $urandom});
    end
    repeat (3) tick();
    n_cmp++;
    if (exp_w_q.size() != 0 || exp_r_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain: %0d writes %0d reads unanswered, required 0", exp_w_q.size(), exp_r_q.size());
      exp_w_q.delete();
      exp_r_q.delete();
    end
  endtask

  task automatic test_random();
    bit dw, dr;
    for (int i = 0; i < 24; i++) begin
      dw = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!dw && !dr) dr = 1'b1;
      run_txn(dw, $urandom_range(1, TC + 2), 4'($urandom_range(0, 15)), AW'($urandom), $urandom,
              dr, $urandom_range(1, TC + 2), 4'($urandom_range(0, 15)), AW'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
    end
    repeat (3) tick();
    n_cmp++;
    if (exp_w_q.size() != 0 || exp_r_q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: %0d writes %0d reads unanswered, required 0", exp_w_q.size(), exp_r_q.size());
      exp_w_q.delete();
      exp_r_q.delete();
    end
  endtask

  task automatic test_drop_and_reset();
    up_rreq = 1'b1; up_raddr = 14'h0020;
    up_wreq = 1'b1; up_waddr = 14'h1234; up_wdata = 32'h87654321;
    tick();
    n_cmp++;
    if ({s_rreq, s_raddr, s_wreq} !== {1'b1, 14'h0020, 1'b1}) begin
      n_err++;
      $display("FAIL drop_first: got rreq %0b raddr %h wreq %0b, required 1 0020 1", s_rreq, s_raddr, s_wreq);
    end
    up_rreq = 1'b0; up_wreq = 1'b0;
    tick();
    up_rreq = 1'b1; up_raddr = 14'h0030;
    tick();
    up_rreq = 1'b0;
    n_cmp++;
    if ({s_rreq, s_raddr} !== {1'b0, 14'h0020}) begin
      n_err++;
      $display("FAIL drop_second: got rreq %0b raddr %h, required 0 0020", s_rreq, s_raddr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({up_wack, up_werr, up_rack, up_rerr, up_rdata, s_wreq, s_waddr, s_wdata,
         s_rreq, s_raddr, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL drop_reset: got waddr %h wdata %h raddr %h state %b, required all 0",
               s_waddr, s_wdata, s_raddr, dbg_state);
    end
    for (int n = 0; n < TC + 4; n++) begin
      s_rack = (n == 2) ? 4'hF : 4'h0;
      s_wack = (n == 3) ? 4'hF : 4'h0;
      tick();
    end
    s_rack = '0;
    s_wack = '0;
  endtask

`ifdef UP_REGMAP_MUX_TIMEOUT_CNT_EN
  task automatic test_timeout_cnt();
    do_reset();
    run_txn(1, 0, 4'd0, 14'h0040, 32'h0, 0, 0, 4'd0, '0, '0);
    run_txn(0, 0, 4'd0, '0, '0, 1, 0, 4'd0, 14'h0041, '0);
    run_txn(1, 0, 4'd0, 14'h0042, 32'h0, 0, 0, 4'd0, '0, '0);
    tick();
    n_cmp++;
    if ({up_timeout_count, up_timeout_addr} !== {16'd3, 14'h0042}) begin
      n_err++;
      $display("FAIL tcnt_three: got count %0d addr %h, required 3 0042", up_timeout_count, up_timeout_addr);
    end
    run_txn(1, 0, 4'd0, 14'h0051, 32'h0, 1, 0, 4'd0, 14'h0050, '0);
    tick();
    n_cmp++;
    if ({up_timeout_count, up_timeout_addr} !== {16'd5, 14'h0051}) begin
      n_err++;
      $display("FAIL tcnt_both: got count %0d addr %h, required 5 0051", up_timeout_count, up_timeout_addr);
    end
    force dut.timeout_cnt_q = 16'hFFFE;
    tick();
    release dut.timeout_cnt_q;
    run_txn(1, 0, 4'd0, 14'h0061, 32'h0, 1, 0, 4'd0, 14'h0060, '0);
    run_txn(0, 0, 4'd0, '0, '0, 1, 0, 4'd0, 14'h0062, '0);
    tick();
    n_cmp++;
    if ({up_timeout_count, up_timeout_addr} !== {16'hFFFF, 14'h0062}) begin
      n_err++;
      $display("FAIL tcnt_saturate: got count %h addr %h, required FFFF 0062", up_timeout_count, up_timeout_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_mux();
    test_timeouts();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_drop_and_reset();
`ifdef UP_REGMAP_MUX_TIMEOUT_CNT_EN
    test_timeout_cnt();
`endif
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/up_regmap_mux.md
Name: up_regmap_mux

Overview:
- Parametrised up-bus fan-out/fan-in stage between up_axi and NUM_SLAVES register slaves (up_*_common, up_*_channel, up_tpl_common).
- Successor to the fixed OR-reduce ack/rdata aggregation inside the TPL regmaps:
  - slave count, address width and timeout are generic;
  - rdata is gated per slave by its rack;
  - independent read/write FSMs with watchdog timeout guarantee the AXI side always receives an ack.

Parameters:
- NUM_SLAVES, 4: number of downstream slaves (1..64).
- ADDR_WIDTH, 14: up-bus word address width.
- TIMEOUT_CYCLES, 64: cycles to wait for a slave ack before a forced response (>= 2).
- TIMEOUT_RDATA, 32'hDEADDEAD: read data returned on a read timeout.

Ports:
- up_clk  in  1  clock; the single clock of the block.
- up_rst  in  1  reset; synchronous, active-high.
- up_wreq  in  1  write request pulse from up_axi.
- up_waddr  in  ADDR_WIDTH  write address.
- up_wdata  in  32  write data.
- up_wack  out  1  write ack pulse to up_axi.
- up_werr  out  1  pulse with up_wack when the write timed out.
- up_rreq  in  1  read request pulse.
- up_raddr  in  ADDR_WIDTH  read address.
- up_rdata  out  32  read data, valid with up_rack.
- up_rack  out  1  read ack pulse.
- up_rerr  out  1  pulse with up_rack when the read timed out.
- s_wreq  out  1  registered write request broadcast to all slaves.
- s_waddr  out  ADDR_WIDTH  registered write address.
- s_wdata  out  32  registered write data.
- s_wack  in  NUM_SLAVES  per-slave write ack.
- s_rreq  out  1  registered read request broadcast.
- s_raddr  out  ADDR_WIDTH  registered read address.
- s_rdata  in  NUM_SLAVES*32  packed slave read data; slave k at [32k+:32].
- s_rack  in  NUM_SLAVES  per-slave read ack.

Behaviour:
- Reset (up_rst=1 at a clock edge):
  - all outputs 0 (s_waddr, s_wdata, s_raddr and up_rdata are also 0);
  - both FSMs go to IDLE and timers clear;
  - a transaction in flight when reset is asserted is abandoned; no ack is ever issued for it.
- Request forwarding:
  - s_wreq/s_waddr/s_wdata are registered copies of up_wreq/up_waddr/up_wdata, 1-cycle latency;
  - address and data registers load only when the request is accepted, so they hold between requests;
  - s_rreq/s_raddr follow the same rules.
- Write FSM, states W_IDLE and W_WAIT:
  - W_IDLE, up_wreq=1: drive s_wreq=1 next cycle, go to W_WAIT, wtimer=0.
  - W_WAIT, |s_wack=1: up_wack=1 next cycle, go to W_IDLE.
  - W_WAIT, no ack and wtimer==TIMEOUT_CYCLES-1: up_wack=1 and up_werr=1 next cycle, go to W_IDLE.
  - W_WAIT, otherwise: wtimer increments.
  - An ack in the same cycle as the timeout condition wins: normal ack, no error.
- Read FSM, states R_IDLE and R_WAIT: identical structure to the write FSM.
  - On ack: up_rdata = OR over k of (s_rdata[k] AND replicate(s_rack[k])), registered alongside up_rack.
  - On timeout: up_rdata = TIMEOUT_RDATA and up_rerr=1.
  - up_rdata returns to 0 the cycle after up_rack.
- Read and write FSMs are fully independent; simultaneous up_wreq and up_rreq are both served.
- Multiple slaves acking in the same cycle: acks are ORed and rdata ORed across acking slaves; no error is raised.
- Protocol rules:
  - a new request of the same type arriving while that FSM is in WAIT is dropped (not queued, not forwarded);
  - slave acks arriving while the FSM is in IDLE are ignored.
- Latency:
  - with ack: request at cycle 0, s_*req at cycle 1, slave ack at cycle t, up_*ack at t+1;
  - with no ack: up_*ack at cycle 1+TIMEOUT_CYCLES.
- Timer width is $clog2(TIMEOUT_CYCLES); the timer never wraps because it clears on entry to WAIT.
- All ack and err outputs are single-cycle pulses.

Optional Feature:
- Macro: UP_REGMAP_MUX_TIMEOUT_CNT_EN.
- Defined:
  - adds output up_timeout_count [15:0], a saturating count of read plus write timeouts;
  - adds output up_timeout_addr [ADDR_WIDTH-1:0], the s_*addr of the most recent timeout;
  - both reset to 0;
  - simultaneous read and write timeouts in one cycle add 2, still saturating at 16'hFFFF, and the write address is captured.
- Undefined: neither port nor the logic exists; behaviour is otherwise identical.

Test Plan:
- NUM_SLAVES=4: up_rreq at cycle 0, raddr=0x0010; slave 2 acks at cycle 2 with 0x12345678 while slaves 0, 1, 3 drive 0xFFFFFFFF without rack -> up_rack=1 at cycle 3, up_rdata=0x12345678, up_rerr=0.
- TIMEOUT_CYCLES=16: up_wreq at cycle 0, no slave acks -> up_wack=1 and up_werr=1 at cycle 17 only; s_wreq=1 at cycle 1 only.
- TIMEOUT_CYCLES=16: read with no ack -> up_rdata=0xDEADDEAD, up_rack=1, up_rerr=1 at cycle 17. Repeat with a slave ack at cycle 16, the last timer cycle -> normal ack at cycle 17, rerr=0.
- Simultaneous up_wreq and up_rreq at cycle 0; slave 0 wacks at cycle 2, slave 3 racks at cycle 4 with 0xA5A5A5A5 -> up_wack at cycle 3, up_rack at cycle 5 with 0xA5A5A5A5.
- Read outstanding; second up_rreq at cycle 2 -> dropped, no second s_rreq. Assert up_rst at cycle 3 -> no up_rack ever for that read. All outputs 0 at cycle 4.
- With UP_REGMAP_MUX_TIMEOUT_CNT_EN defined: three timeouts at addresses 0x40, 0x41, 0x42 -> up_timeout_count=3, up_timeout_addr=0x42. Force the count to 0xFFFF, then one more timeout -> count stays 0xFFFF.
